// File: rtl/vote_collector_if.sv
// rtl/vote_collector_if.sv - voter key / start inputs and ballot outputs of vote_collector
//
// Purpose : bundles the control inputs (start, raw keys) and the ballot outputs
//           (abc, valid, busy, remaining) of the vote collector.
// Ports   : master - drives start/key_a/key_b/key_c, observes the ballot
//           slave  - the collector itself
interface vote_collector_if #(
    parameter int WINDOW_CYCLES = 16
);
    localparam int TW = $clog2(WINDOW_CYCLES + 1);

    logic          start;
    logic          key_a;
    logic          key_b;
    logic          key_c;
    logic [2:0]    abc;
    logic          valid;
    logic          busy;
    logic [TW-1:0] remaining;

    modport master (
        output start, key_a, key_b, key_c,
        input  abc, valid, busy, remaining
    );

    modport slave (
        input  start, key_a, key_b, key_c,
        output abc, valid, busy, remaining
    );
endinterface

// File: rtl/vote_collector.sv
// rtl/vote_collector.sv - debounced three-voter ballot collector with timed window
//
// Purpose : synchronises and debounces keys A/B/C, opens a voting window on start,
//           latches each voter's first press and presents a frozen ballot when the
//           window closes (timeout or all three voted).
// Ports   : clk        - system clock, rising edge
//           rst_n      - asynchronous active-low reset
//           bus.start  - opens a window from IDLE or DONE
//           bus.key_*  - raw voter keys, asynchronous, active high
//           bus.abc    - frozen ballot {A,B,C}, zero unless valid
//           bus.valid  - completed ballot present (DONE)
//           bus.busy   - window open (VOTING)
//           bus.remaining - cycles left in the window, zero outside VOTING
module vote_collector #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WINDOW_CYCLES   = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    vote_collector_if.slave bus
);
    localparam int TW = $clog2(WINDOW_CYCLES + 1);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_VOTING,
        ST_DONE
    } state_t;

    // Bit 2 = A, bit 1 = B, bit 0 = C throughout.
    logic [2:0] keys;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] level;
    logic [2:0] press;

    assign keys = {bus.key_a, bus.key_b, bus.key_c};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
        end else begin
            sync1 <= keys;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_db
        logic [CW-1:0] cnt;
        logic          lvl;
        logic          lvl_d;

        // The level flips only after the synced input has disagreed with it for
        // DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt   <= '0;
                lvl   <= 1'b0;
                lvl_d <= 1'b0;
            end else begin
                lvl_d <= lvl;
                if (sync2[i] == lvl) begin
                    cnt <= '0;
                end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt <= '0;
                    lvl <= sync2[i];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign level[i] = lvl;
        assign press[i] = lvl & ~lvl_d;
    end

    state_t        state_q, state_d;
    logic [2:0]    votes_q, votes_d;
    logic [2:0]    abc_q, abc_d;
    logic [TW-1:0] rem_q, rem_d;
    logic [2:0]    all_votes;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            votes_q <= 3'b000;
            abc_q   <= 3'b000;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            votes_q <= votes_d;
            abc_q   <= abc_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        votes_d   = votes_q;
        abc_d     = abc_q;
        rem_d     = rem_q;
        // Include this cycle's presses so a final-cycle press still counts.
        all_votes = votes_q | press;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_VOTING;
                    votes_d = 3'b000;
                    abc_d   = 3'b000;
                    rem_d   = TW'(WINDOW_CYCLES - 1);
                end
            end
            ST_VOTING: begin
                if (rem_q == '0 || all_votes == 3'b111) begin
                    state_d = ST_DONE;
                    abc_d   = all_votes;
                    votes_d = all_votes;
                    rem_d   = '0;
                end else begin
                    votes_d = all_votes;
                    rem_d   = rem_q - TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                votes_d = 3'b000;
                abc_d   = 3'b000;
                rem_d   = '0;
            end
        endcase
    end

    assign bus.abc       = abc_q;
    assign bus.valid     = (state_q == ST_DONE);
    assign bus.busy      = (state_q == ST_VOTING);
    assign bus.remaining = rem_q;
endmodule
